// File: rtl/pll_cfg_responder_if.sv
// Avalon-MM management bus between the core top level (master) and the
// PLL reconfiguration responder (slave).
//
// Handshake: a transfer is accepted at a rising mgmt_clk edge where
// mgmt_write or mgmt_read is 1 and mgmt_waitrequest is 0. Request, address
// and data are sampled only at that edge, so a master may drop the request
// right after it. A cycle with both write and read set is a write.
// mgmt_readdata is valid in the cycle after an accepted read and holds until
// the next accepted read.
interface pll_cfg_responder_if;
  logic [5:0]  mgmt_address;
  logic        mgmt_write;
  logic [31:0] mgmt_writedata;
  logic        mgmt_read;
  logic [31:0] mgmt_readdata;
  logic        mgmt_waitrequest;

  modport master (
    output mgmt_address, mgmt_write, mgmt_writedata, mgmt_read,
    input  mgmt_readdata, mgmt_waitrequest
  );

  modport slave (
    input  mgmt_address, mgmt_write, mgmt_writedata, mgmt_read,
    output mgmt_readdata, mgmt_waitrequest
  );
endinterface

// File: rtl/pll_cfg_responder.sv
// PLL reconfiguration management responder. Shadows the mode and
// fractional-K registers, acknowledges writes with a short stall, and on a
// start write runs a timed apply phase before publishing the new K word.
// Mode 0 stalls the bus through the whole apply; mode 1 lets the master poll
// the status register while writes are silently dropped.
module pll_cfg_responder #(
  parameter int unsigned ACK_CYCLES   = 2,
  parameter int unsigned APPLY_CYCLES = 16,
  parameter logic [31:0] K_RESET      = 32'hD8EC_8D00
) (
  input  logic                      mgmt_clk,
  input  logic                      mgmt_reset,
  pll_cfg_responder_if.slave        mgmt,
  output logic [31:0]               frac_k,
  output logic                      frac_k_valid,
  output logic                      busy,
  output logic [1:0]                dbg_state
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] ACK_LOAD   = ACK_CYCLES[CNT_W-1:0];
  localparam logic [CNT_W-1:0] APPLY_LOAD = APPLY_CYCLES[CNT_W-1:0];

  localparam logic [5:0] ADDR_MODE   = 6'd0;
  localparam logic [5:0] ADDR_STATUS = 6'd1;
  localparam logic [5:0] ADDR_START  = 6'd2;
  localparam logic [5:0] ADDR_K      = 6'd7;

  // S_INIT holds waitrequest high for the first edge after reset release.
  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_IDLE  = 2'd1,
    S_ACK   = 2'd2,
    S_APPLY = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              mode;        // 0 = waitrequest mode, 1 = polling mode
  logic              mode_lat;    // mode captured with the start write
  logic              start_pend;  // ACK in progress belongs to a start write
  logic [31:0]       shadow_k;
  logic              waitreq;
  logic              reg_wr;
  logic              start_acc;
  logic              enter_apply;
  logic              apply_done;
  logic              rd_acc;
  logic [31:0]       rd_mux;

  assign mgmt.mgmt_waitrequest = waitreq;
  assign dbg_state             = state;

  // Reads only win when no write shares the edge; they never stall.
  assign rd_acc = mgmt.mgmt_read & ~mgmt.mgmt_write & ~waitreq;

  // State and counter register.
  always_ff @(posedge mgmt_clk or posedge mgmt_reset) begin
    if (mgmt_reset) begin
      state <= S_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state, counter reload/decrement and per-state bus stall.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    waitreq     = 1'b1;
    reg_wr      = 1'b0;
    start_acc   = 1'b0;
    enter_apply = 1'b0;
    apply_done  = 1'b0;
    case (state)
      S_INIT: begin
        state_nxt = S_IDLE;
      end
      S_IDLE: begin
        waitreq = 1'b0;
        if (mgmt.mgmt_write) begin
          reg_wr    = 1'b1;
          start_acc = (mgmt.mgmt_address == ADDR_START);
          state_nxt = S_ACK;
          cnt_nxt   = ACK_LOAD;
        end
      end
      S_ACK: begin
        if (cnt != '0) cnt_nxt = cnt - 1'b1;
        if (cnt <= 1) begin
          if (start_pend) begin
            state_nxt   = S_APPLY;
            cnt_nxt     = APPLY_LOAD;
            enter_apply = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_APPLY: begin
        // Writes seen here are accepted (in polling mode) and dropped.
        waitreq = ~mode_lat;
        if (cnt != '0) cnt_nxt = cnt - 1'b1;
        if (cnt <= 1) begin
          state_nxt  = S_IDLE;
          apply_done = 1'b1;
        end
      end
    endcase
  end

  // Read data selection from the register map.
  always_comb begin
    rd_mux = '0;
    case (mgmt.mgmt_address)
      ADDR_MODE:   rd_mux = {31'b0, mode};
      ADDR_STATUS: rd_mux = {31'b0, busy};
      ADDR_K:      rd_mux = shadow_k;
      default:     rd_mux = '0;
    endcase
  end

  // Register file, apply bookkeeping, K publication and read data.
  always_ff @(posedge mgmt_clk or posedge mgmt_reset) begin
    if (mgmt_reset) begin
      mode               <= 1'b0;
      mode_lat           <= 1'b0;
      start_pend         <= 1'b0;
      shadow_k           <= K_RESET;
      busy               <= 1'b0;
      frac_k             <= K_RESET;
      frac_k_valid       <= 1'b0;
      mgmt.mgmt_readdata <= '0;
    end else begin
      frac_k_valid <= apply_done;
      if (reg_wr) begin
        case (mgmt.mgmt_address)
          ADDR_MODE: mode     <= mgmt.mgmt_writedata[0];
          ADDR_K:    shadow_k <= mgmt.mgmt_writedata;
          default:   ;
        endcase
      end
      if (start_acc) begin
        start_pend <= 1'b1;
        busy       <= 1'b1;
        mode_lat   <= mode;
      end
      if (enter_apply) start_pend <= 1'b0;
      if (apply_done) begin
        busy   <= 1'b0;
        frac_k <= shadow_k;
      end
      if (rd_acc) mgmt.mgmt_readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_pll_cfg_responder.sv
// Bench for pll_cfg_responder: reset/table vectors, directed multi-cycle
// sequences and random traffic against a timestamp-based reference model.
module tb_pll_cfg_responder;

  localparam int unsigned ACK   = 2;
  localparam int unsigned APP   = 16;
  localparam logic [31:0] K_RST = 32'hD8EC_8D00;

  logic        mgmt_clk;
  logic        mgmt_reset;
  logic [31:0] frac_k;
  logic        frac_k_valid;
  logic        busy;
  logic [1:0]  dbg_state;

  pll_cfg_responder_if bus();

  pll_cfg_responder #(
    .ACK_CYCLES(ACK),
    .APPLY_CYCLES(APP),
    .K_RESET(K_RST)
  ) dut (
    .mgmt_clk(mgmt_clk),
    .mgmt_reset(mgmt_reset),
    .mgmt(bus),
    .frac_k(frac_k),
    .frac_k_valid(frac_k_valid),
    .busy(busy),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial mgmt_clk = 1'b0;
  always #5 mgmt_clk = ~mgmt_clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Works in edge timestamps: m_e counts edges since reset release; a write
  // accepted at edge e stalls the bus until m_free_at, a start schedules the
  // K publication at m_apply_end.
  int          m_e, m_free_at, m_start_e, m_apply_end;
  logic        m_mode, m_busy, m_valid, m_wr;
  logic [31:0] m_shadow, m_frac, m_rd;

  task automatic model_reset();
    m_e = 0; m_free_at = 1; m_start_e = 0; m_apply_end = 0;
    m_mode = 1'b0; m_busy = 1'b0; m_valid = 1'b0; m_wr = 1'b1;
    m_shadow = K_RST; m_frac = K_RST; m_rd = '0;
  endtask

  task automatic model_edge();
    logic acc;
    if (mgmt_reset) begin
      model_reset();
      return;
    end
    m_e++;
    acc = !m_wr;
    if (acc && bus.mgmt_write) begin
      if (!(m_e > m_start_e && m_e <= m_apply_end)) begin
        if (bus.mgmt_address == 6'd0) m_mode = bus.mgmt_writedata[0];
        if (bus.mgmt_address == 6'd7) m_shadow = bus.mgmt_writedata;
        if (bus.mgmt_address == 6'd2) begin
          m_start_e   = m_e;
          m_apply_end = m_e + ACK + APP;
          m_free_at   = m_e + ACK + (m_mode ? 0 : APP);
        end else begin
          m_free_at = m_e + ACK;
        end
      end
    end else if (acc && bus.mgmt_read) begin
      case (bus.mgmt_address)
        6'd0:    m_rd = {31'b0, m_mode};
        6'd1:    m_rd = {31'b0, m_busy};
        6'd7:    m_rd = m_shadow;
        default: m_rd = '0;
      endcase
    end
    m_valid = (m_e == m_apply_end);
    if (m_valid) m_frac = m_shadow;
    m_busy = (m_e >= m_start_e) && (m_e < m_apply_end);
    m_wr   = (m_e < m_free_at);
  endtask

  task automatic check_outputs();
    chk("cyc_waitrequest", {31'b0, bus.mgmt_waitrequest}, {31'b0, m_wr});
    chk("cyc_readdata", bus.mgmt_readdata, m_rd);
    chk("cyc_frac_k", frac_k, m_frac);
    chk("cyc_frac_k_valid", {31'b0, frac_k_valid}, {31'b0, m_valid});
    chk("cyc_busy", {31'b0, busy}, {31'b0, m_busy});
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge mgmt_clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.mgmt_waitrequest !== 1'b0 && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL wait_ready_timeout actual=waitrequest_high expected=low");
    end
  endtask

  task automatic do_write(input logic [5:0] a, input logic [31:0] d);
    wait_ready();
    bus.mgmt_address = a; bus.mgmt_writedata = d; bus.mgmt_write = 1'b1;
    step();
    bus.mgmt_write = 1'b0;
  endtask

  task automatic do_read(input logic [5:0] a, output logic [31:0] d);
    wait_ready();
    bus.mgmt_address = a; bus.mgmt_read = 1'b1;
    step();
    bus.mgmt_read = 1'b0;
    d = bus.mgmt_readdata;
  endtask

  task automatic count_stall(output int n);
    n = 0;
    while (bus.mgmt_waitrequest === 1'b1 && n < 100) begin
      n++;
      step();
    end
  endtask

  task automatic wait_not_busy();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL busy_timeout actual=busy_high expected=low");
    end
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    bit          is_write;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [31:0] v;
    int n, ones;
    logic [5:0] addr_pick[6];

    vecs[0]  = '{1'b0, 6'd7,  32'h0,         32'hD8EC_8D00};
    vecs[1]  = '{1'b1, 6'd0,  32'h1,         32'h0};
    vecs[2]  = '{1'b0, 6'd0,  32'h0,         32'h1};
    vecs[3]  = '{1'b1, 6'd0,  32'hFFFF_FFFE, 32'h0};
    vecs[4]  = '{1'b0, 6'd0,  32'h0,         32'h0};
    vecs[5]  = '{1'b1, 6'd7,  32'h0BAD_F00D, 32'h0};
    vecs[6]  = '{1'b0, 6'd7,  32'h0,         32'h0BAD_F00D};
    vecs[7]  = '{1'b0, 6'd1,  32'h0,         32'h0};
    vecs[8]  = '{1'b1, 6'd1,  32'hFFFF_FFFF, 32'h0};
    vecs[9]  = '{1'b0, 6'd1,  32'h0,         32'h0};
    vecs[10] = '{1'b0, 6'd2,  32'h0,         32'h0};
    vecs[11] = '{1'b0, 6'd63, 32'h0,         32'h0};
    addr_pick = '{6'd0, 6'd1, 6'd2, 6'd7, 6'd5, 6'd3};

    // Reset: outputs at reset values while reset is held.
    bus.mgmt_address = '0; bus.mgmt_write = 1'b0; bus.mgmt_writedata = '0;
    bus.mgmt_read = 1'b0;
    mgmt_reset = 1'b1;
    model_reset();
    #1;
    check_outputs();
    chk("rst_waitrequest", {31'b0, bus.mgmt_waitrequest}, 32'd1);
    step(); step();
    mgmt_reset = 1'b0;
    step();
    chk("rst_release_wr_low", {31'b0, bus.mgmt_waitrequest}, 32'd0);

    // Table-driven register accesses.
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].is_write) begin
        do_write(vecs[i].addr, vecs[i].data);
      end else begin
        exp_q.push_back(vecs[i].exp_rd);
        do_read(vecs[i].addr, v);
        chk($sformatf("tbl_rd_%0d", i), v, exp_q.pop_front());
      end
    end

    // Mode 0 apply: 18-cycle stall, single valid pulse as waitrequest falls.
    do_write(6'd0, 32'd0);
    do_write(6'd7, 32'd3268298314);
    do_write(6'd2, 32'd0);
    count_stall(n);
    chk("t2_stall_cycles", n, 18);
    chk("t2_valid_at_fall", {31'b0, frac_k_valid}, 32'd1);
    chk("t2_frac_k", frac_k, 32'd3268298314);
    step();
    chk("t2_valid_one_cycle", {31'b0, frac_k_valid}, 32'd0);

    // Mode 1 apply: short stall, then status polling.
    do_write(6'd0, 32'd1);
    do_write(6'd7, 32'd5);
    do_write(6'd2, 32'd0);
    count_stall(n);
    chk("t3_stall_cycles", n, 2);
    ones = 0;
    for (int i = 0; i < 40; i++) begin
      do_read(6'd1, v);
      if (v == 32'd1) ones++;
      else break;
    end
    chk("t3_poll_ones", ones, 16);
    chk("t3_frac_k", frac_k, 32'd5);
    do_write(6'd2, 32'd0);
    do_write(6'd7, 32'd9);
    wait_not_busy();
    do_read(6'd7, v);
    chk("t3_drop_k_write", v, 32'd5);

    // Read and write together: write wins, readdata holds.
    bus.mgmt_address = 6'd7; bus.mgmt_writedata = 32'h1234;
    bus.mgmt_write = 1'b1; bus.mgmt_read = 1'b1;
    step();
    bus.mgmt_write = 1'b0; bus.mgmt_read = 1'b0;
    chk("t4_rd_hold", bus.mgmt_readdata, 32'd5);
    do_read(6'd7, v);
    chk("t4_rd_new", v, 32'h1234);

    // Reset in the middle of a mode 0 apply.
    do_write(6'd0, 32'd0);
    do_write(6'd7, 32'hCAFE_F00D);
    do_write(6'd2, 32'd0);
    repeat (ACK + 8) step();
    mgmt_reset = 1'b1;
    model_reset();
    #1;
    chk("t5_busy", {31'b0, busy}, 32'd0);
    chk("t5_frac_k", frac_k, K_RST);
    chk("t5_valid", {31'b0, frac_k_valid}, 32'd0);
    step(); step();
    mgmt_reset = 1'b0;
    repeat (20) step();
    chk("t5_no_late_apply", frac_k, K_RST);
    do_write(6'd7, 32'h1357_9BDF);
    do_write(6'd2, 32'd0);
    wait_not_busy();
    step();
    chk("t5_fresh_frac_k", frac_k, 32'h1357_9BDF);

    // Unmapped address write.
    do_write(6'd5, 32'hFFFF_FFFF);
    count_stall(n);
    chk("t6_stall_cycles", n, 2);
    do_read(6'd5, v);
    chk("t6_rd_unmapped", v, 32'd0);
    chk("t6_frac_k", frac_k, 32'h1357_9BDF);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      bus.mgmt_write     = ($urandom_range(0, 3) == 0);
      bus.mgmt_read      = ($urandom_range(0, 2) == 0);
      bus.mgmt_address   = addr_pick[$urandom_range(0, 5)];
      bus.mgmt_writedata = $urandom;
      step();
    end
    bus.mgmt_write = 1'b0; bus.mgmt_read = 1'b0;
    wait_not_busy();
    wait_ready();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
